// File: rtl/des_pkg.sv
// Shared DES sequencing definitions: FSM states, round count, mode encodings
// and the per-round C/D rotate amounts for encrypt and decrypt.
package des_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_HOLD
  } state_t;

  localparam int DES_ROUNDS = 16;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [1:0] ENC_SHIFTS [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt rotates right before each subkey; round 1 needs no rotate because
  // the encrypt rotations sum to a full 28-bit turn, so C/D already sits at K16.
  localparam logic [1:0] DEC_SHIFTS [DES_ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_key_shift_lut.sv
// Maps round number (1..16) and mode to the C/D rotate amount; 0 outside rounds.
module des_key_shift_lut
  import des_pkg::*;
(
  input  logic [4:0] round_num,
  input  logic       mode,
  output logic [1:0] key_shift
);

  logic [3:0] idx;

  always_comb begin
    key_shift = 2'd0;
    idx       = 4'(round_num - 5'd1);
    if (round_num >= 5'd1 && round_num <= 5'(DES_ROUNDS)) begin
      key_shift = (mode == MODE_DEC) ? DEC_SHIFTS[idx] : ENC_SHIFTS[idx];
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencing controller for the iterative DES core: one block at a time through
// IP load, 16 rounds and final capture, with Moore-decoded strobes.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_LOAD  | datapath loads IP / PC-1
//   ST_ROUND | Feistel rounds, ROUND_CYCLES clocks each
//   ST_FINAL | output register captures result
//   ST_HOLD  | result offered until consumer takes it
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  output logic       load_ip,
  output logic       round_en,
  output logic [4:0] round_num,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] round_q;
  logic [1:0] sub_q;
  logic       mode_q;
  logic       in_round;
  logic       last_sub;
  logic       last_round;

  assign in_round   = (state == ST_ROUND);
  assign last_sub   = (sub_q == 2'(ROUND_CYCLES - 1));
  assign last_round = (round_q == 5'(DES_ROUNDS));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_ROUND;
      ST_ROUND: if (last_sub && last_round) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= 5'd0;
      sub_q   <= 2'd0;
      mode_q  <= MODE_ENC;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) mode_q <= mode;
        ST_LOAD: begin
          round_q <= 5'd1;
          sub_q   <= 2'd0;
        end
        ST_ROUND: begin
          if (last_sub) begin
            sub_q   <= 2'd0;
            round_q <= last_round ? 5'd0 : round_q + 5'd1;
          end else begin
            sub_q <= sub_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign load_ip   = (state == ST_LOAD);
  assign round_en  = in_round && last_sub;
  assign round_num = in_round ? round_q : 5'd0;
  assign key_dir   = in_round && mode_q;
  assign capture   = (state == ST_FINAL);
  assign out_valid = (state == ST_HOLD);

  des_key_shift_lut u_shift_lut (
    .round_num (round_num),
    .mode      (mode_q),
    .key_shift (key_shift)
  );

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencing controller for the iterative DES core. It accepts one 64-bit block request at a time and drives the datapath through its phases: initial-permutation load, 16 Feistel rounds with the matching key-schedule shifts for encrypt or decrypt, then capture of the swapped/final-permuted result from the output stage. It owns the request/result handshakes, so the datapath registers never see a new block mid-operation.

## Interface
- `ROUND_CYCLES`, default 1: clock cycles per Feistel round (1..4); allows a multicycle round path.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request holds a block and key.
- `in_ready`  out  1  controller can accept a request.
- `mode`  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- `load_ip`  out  1  datapath loads L/R from the initial permutation and C/D from PC-1.
- `round_en`  out  1  datapath registers one round result (L/R and C/D update).
- `round_num`  out  5  current round, 1..16; 0 when not in a round.
- `key_shift`  out  2  C/D rotate amount for this round (0, 1 or 2).
- `key_dir`  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt).
- `capture`  out  1  output register latches the final-stage result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, HOLD.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `mode` into `mode_q` and go to LOAD.
- LOAD (1 cycle): `load_ip`=1. Then go to ROUND with round 1 and the sub-cycle counter at 0.
- ROUND: `round_num` = current round. The sub-cycle counter counts 0..ROUND_CYCLES-1. `round_en`=1 only on the last sub-cycle.
- On `round_en`, the round counter increments; after round 16, go to FINAL.
- `key_shift` and `key_dir` hold valid for the whole round. `key_dir` = `mode_q`.
- Encrypt shift table, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt shift table, rounds 1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- The rotate is applied before that round's subkey is formed, so the decrypt sequence yields K16..K1.
- FINAL (1 cycle): `capture`=1. Then go to HOLD.
- HOLD: `out_valid`=1 until `out_ready`; on the handshake cycle go to IDLE.
- Handshake rules:
  - `in_ready` is low outside IDLE; requests are not queued.
  - `out_valid` never drops without `out_ready`.
  - `mode` changes after accept have no effect.
- Reset, including mid-operation: next state IDLE, `mode_q`=0, all counters 0. The in-flight block is discarded with no `capture`.
- Output values after reset: `in_ready`=1; every other output, including `round_num` and `key_shift`, is 0.
- All outputs are decoded from registered state (Moore); no input-to-output combinational path.

## Timing
- Accept at edge 0.
- LOAD occupies cycle 1.
- Rounds occupy cycles 2 .. 1+16·ROUND_CYCLES.
- FINAL follows the last round.
- `out_valid` first high 3+16·ROUND_CYCLES cycles after accept (19 for ROUND_CYCLES=1).
- If `out_ready` is already high, IDLE follows one cycle later. The next accept is possible then, so minimum throughput is one block per 20 cycles at ROUND_CYCLES=1.
- Exactly 16 `round_en` pulses, one `load_ip` and one `capture` occur per block.

## Structure
- Shared package `des_pkg`:
  - FSM state enum.
  - `DES_ROUNDS`=16.
  - Encrypt and decrypt shift tables as 16-entry constant arrays.
  - Mode encodings.
- One natural sub-module, `des_key_shift_lut`: combinational map of round number and mode to `key_shift`. The datapath key-schedule testbench reuses it.
- The controller contains only the FSM, the 5-bit round counter, a 2-bit sub-cycle counter and `mode_q`.

## Test plan
- Reset then idle: hold `rst` 2 cycles. Expect `in_ready`=1, `busy`=0 and all strobes 0 for 10 cycles with `in_valid`=0.
- Encrypt, ROUND_CYCLES=1: accept with `mode`=0.
  - `load_ip` in cycle 1.
  - `round_en` in cycles 2..17 with `round_num` 1..16.
  - `key_shift` sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, `key_dir`=0.
  - `capture` in cycle 18, `out_valid` in cycle 19.
- Decrypt, ROUND_CYCLES=2, with the datapath attached:
  - Key 0x133457799BBCDFF1, block 0x85E813540F0AB405.
  - Expect result 0x0123456789ABCDEF.
  - Expect `key_shift` round 1 = 0, `out_valid` at cycle 35.
- Encrypt the same key and 0x0123456789ABCDEF through the datapath. Expect 0x85E813540F0AB405.
- Backpressure and flip: hold `out_ready`=0 for 7 cycles in HOLD, and toggle `mode` and `in_valid` throughout.
  - `out_valid` stays 1, result stable, `in_ready` stays 0.
  - One cycle after `out_ready` goes high, `in_ready`=1.
- Reset mid-operation: assert `rst` at round 9.
  - Next cycle: IDLE, `round_num`=0, no `capture`.
  - A new encrypt then completes with correct 19-cycle latency.
